// File: rtl/double_share_pkg.sv
// Shared constants, types and helpers for the shared doubling arbiter.
package double_share_pkg;

    localparam int DEFAULT_DATA_W  = 8;
    localparam int DEFAULT_NUM_REQ = 4;
    localparam int GRANT_CNT_W     = 16;

    // Response slot occupancy
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // Doubling on a wide operand; callers truncate to their own DATA_W
    function automatic logic [63:0] dbl(input logic [63:0] op);
        return {op[62:0], 1'b0};
    endfunction

endpackage

// File: rtl/double_share_arbiter_rr.sv
// Round-robin picker: first requester at or above base, wrapping.
module rr_arbiter #(
    parameter int N = 4,
    localparam int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] base,
    input  logic            en,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] idx,
    output logic            any_grant
);

    int unsigned k;

    // Scan from base upward, modulo N, and take the first pending request
    always_comb begin
        grant     = '0;
        idx       = '0;
        any_grant = 1'b0;
        k         = 0;
        if (en) begin
            for (int unsigned i = 0; i < N; i++) begin
                k = (int'(base) + i) % N;
                if (!any_grant && req[k]) begin
                    grant[k]  = 1'b1;
                    idx       = ID_W'(k);
                    any_grant = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/double_share_arbiter.sv
// Shared doubler: round-robin grant into one registered response slot.
module double_share_arbiter
    import double_share_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int DATA_W  = DEFAULT_DATA_W,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [DATA_W-1:0]         resp_data,
    output logic [ID_W-1:0]           resp_id,
    output logic                      resp_ovf,
    output logic [GRANT_CNT_W-1:0]    grant_count
);

    slot_state_t      state;
    logic [ID_W-1:0]  rr_ptr;
    logic             accept;
    logic [ID_W-1:0]  arb_idx;
    logic             transfer;
    logic [DATA_W-1:0] op_sel;

    assign accept     = en && !rst && (state == SLOT_EMPTY || resp_ready);
    assign resp_valid = (state == SLOT_FULL);
    assign op_sel     = req_data[arb_idx*DATA_W +: DATA_W];

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req       (req_valid),
        .base      (rr_ptr),
        .en        (accept),
        .grant     (req_ready),
        .idx       (arb_idx),
        .any_grant (transfer)
    );

    // Response slot, round-robin pointer and grant counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SLOT_EMPTY;
            resp_data   <= '0;
            resp_id     <= '0;
            resp_ovf    <= 1'b0;
            rr_ptr      <= '0;
            grant_count <= '0;
        end else if (transfer) begin
            state       <= SLOT_FULL;
            resp_data   <= DATA_W'(dbl(64'(op_sel)));
            resp_ovf    <= op_sel[DATA_W-1];
            resp_id     <= arb_idx;
            rr_ptr      <= (arb_idx == ID_W'(NUM_REQ-1)) ? '0 : arb_idx + ID_W'(1);
            grant_count <= grant_count + GRANT_CNT_W'(1);
        end else if (state == SLOT_FULL && resp_ready) begin
            state <= SLOT_EMPTY;
        end
    end

endmodule
